// File: rtl/alu_defs_pkg.sv
// Shared ALU control encodings, ALUOp/funct codes and the ID/EX bundle.
// alu_ctl_decode returns {illegal, ALUctl}.
package alu_defs_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctl;
    logic        illegal;
    logic [4:0]  dest;
    logic        reg_write;
  } id_ex_t;

  function automatic logic [4:0] alu_ctl_decode(
    input logic [1:0] alu_op,
    input logic [5:0] funct
  );
    logic [4:0] r;
    r = {1'b0, ALU_ADD};
    unique case (alu_op)
      ALUOP_ADD: r = {1'b0, ALU_ADD};
      ALUOP_SUB: r = {1'b0, ALU_SUB};
      ALUOP_OR:  r = {1'b0, ALU_OR};
      ALUOP_FUNCT: begin
        unique case (funct)
          FUNCT_ADD: r = {1'b0, ALU_ADD};
          FUNCT_SUB: r = {1'b0, ALU_SUB};
          FUNCT_AND: r = {1'b0, ALU_AND};
          FUNCT_OR:  r = {1'b0, ALU_OR};
          FUNCT_NOR: r = {1'b0, ALU_NOR};
          FUNCT_SLT: r = {1'b0, ALU_SLT};
          default:   r = {1'b1, ALU_ADD};
        endcase
      end
      default: r = {1'b0, ALU_ADD};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/reg_file_32x32.sv
// 2-read 1-write register file, r0 hardwired to zero.
// Reads are combinational; write bypass lives in the parent.
module reg_file_32x32
  import alu_defs_pkg::*;
#(
  parameter int NREGS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);

  logic [31:0] mem [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        mem[i] <= '0;
      end
    end else if (we && wa != 5'd0) begin
      mem[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == 5'd0) ? 32'd0 : mem[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'd0 : mem[ra2];

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX stage feeding the 32-bit ALU: operand fetch, B select,
// ALUctl decode and a one-entry valid/ready output register.
module alu_operand_stage
  import alu_defs_pkg::*;
#(
  parameter int NREGS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [15:0] imm16,
  input  logic        imm_zext,
  input  logic        alu_src,
  input  logic [1:0]  alu_op,
  input  logic [5:0]  funct,
  input  logic [4:0]  dest,
  input  logic        reg_write,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic [3:0]  ALUctl,
  output logic        illegal,
  output logic [4:0]  out_dest,
  output logic        out_reg_write
);

  logic [31:0] rf_rs;
  logic [31:0] rf_rt;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] imm_ext;
  logic [4:0]  dec;
  logic        wb_live;
  logic        load;
  id_ex_t      nxt;
  id_ex_t      q;
  logic        vld;

  reg_file_32x32 #(.NREGS(NREGS)) u_rf (
    .clk (clk),
    .rst (rst),
    .ra1 (rs),
    .ra2 (rt),
    .rd1 (rf_rs),
    .rd2 (rf_rt),
    .we  (wb_en),
    .wa  (wb_addr),
    .wd  (wb_data)
  );

  // Same-cycle write-back wins over the stale array contents.
  assign wb_live = wb_en && (wb_addr != 5'd0);
  assign rs_data = (wb_live && wb_addr == rs) ? wb_data : rf_rs;
  assign rt_data = (wb_live && wb_addr == rt) ? wb_data : rf_rt;

  assign imm_ext = imm_zext ? {16'h0, imm16}
                            : {{16{imm16[15]}}, imm16};
  assign dec = alu_ctl_decode(alu_op, funct);

  always_comb begin
    nxt           = '0;
    nxt.a         = rs_data;
    nxt.b         = alu_src ? imm_ext : rt_data;
    nxt.ctl       = dec[3:0];
    nxt.illegal   = dec[4];
    nxt.dest      = dest;
    nxt.reg_write = reg_write;
  end

  assign in_ready = !vld || out_ready;
  assign load     = in_valid && in_ready && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= 1'b0;
      q   <= '0;
    end else if (load) begin
      vld <= 1'b1;
      q   <= nxt;
    end else if (flush || out_ready) begin
      vld <= 1'b0;
    end
  end

  assign out_valid     = vld;
  assign A             = q.a;
  assign B             = q.b;
  assign ALUctl        = q.ctl;
  assign illegal       = q.illegal;
  assign out_dest      = q.dest;
  assign out_reg_write = q.reg_write;

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- ID/EX stage directly upstream of the 32-bit ALU (ALU_32bit): owns the 32x32 register file, decodes ALUOp/funct into the 4-bit ALUctl, and forms operand B from rt or an extended immediate.
- Registers A, B, ALUctl and destination info for one cycle, then presents them to the ALU under a valid/ready handshake.
- Write-back from downstream enters through a dedicated write port.

Parameters:
- NREGS, 32, register count; the address width is fixed at 5 bits.
- RESET_PC_UNUSED, none. There are no further parameters; all widths are fixed at 32-bit data.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage can accept
- rs  in  5  source register for A
- rt  in  5  source register for B when alu_src=0
- imm16  in  16  instruction immediate
- imm_zext  in  1  1=zero-extend imm16, 0=sign-extend
- alu_src  in  1  1=B from immediate, 0=B from rt
- alu_op  in  2  00 add, 01 sub, 10 funct-decoded, 11 or
- funct  in  6  R-type function field
- dest  in  5  destination register
- reg_write  in  1  instruction writes dest
- wb_en  in  1  register-file write enable
- wb_addr  in  5  write address
- wb_data  in  32  write data
- flush  in  1  kill the held/incoming instruction
- out_valid  out  1  A/B/ALUctl valid
- out_ready  in  1  ALU side accepts
- A  out  32  ALU operand A
- B  out  32  ALU operand B
- ALUctl  out  4  ALU control
- illegal  out  1  unknown funct under alu_op=10
- out_dest  out  5  registered dest
- out_reg_write  out  1  registered reg_write

Behaviour:
- Reset (rst=1 at an edge):
  - out_valid, A, B, ALUctl, illegal, out_dest and out_reg_write all go to 0.
  - All 32 registers clear to 0.
  - Any in-flight instruction is dropped, and in_valid is ignored in that cycle.
- Handshake:
  - in_ready = !out_valid || out_ready, computed combinationally.
  - load = in_valid && in_ready && !flush.
  - On load, all outputs capture the new values and out_valid becomes 1 at the next edge. Latency is 1 cycle.
  - If there is no load and out_ready=1, out_valid goes to 0.
  - While out_valid=1 and out_ready=0, every output holds stable. Operands are not re-read, so a later write to rs or rt does not alter the held A or B.
- Flush:
  - Next edge: out_valid=0.
  - Flush overrides a simultaneous load.
  - The register-file write still occurs during flush.
- Register file:
  - Two combinational reads, one write at the clock edge.
  - The write occurs whenever wb_en=1 and wb_addr!=0, independent of stall or flush.
  - Register 0 always reads 0, and writes to register 0 are ignored.
- Bypass: if wb_en=1 and wb_addr==rs (or rt) and wb_addr!=0 in the load cycle, the read returns wb_data, not the stale register contents.
- Immediate: sign-extend gives {{16{imm16[15]}},imm16}; zero-extend gives {16'h0,imm16}.
- B select: alu_src=1 takes the extended immediate; otherwise B takes rt data.
- ALUctl decode:
  - alu_op 00 gives 0010 (add).
  - alu_op 01 gives 0110 (sub).
  - alu_op 11 gives 0001 (or).
  - alu_op 10 decodes funct:
    - 100000 gives 0010.
    - 100010 gives 0110.
    - 100100 gives 0000.
    - 100101 gives 0001.
    - 100111 gives 1100 (nor).
    - 101010 gives 0111 (slt).
    - Any other funct gives 0010 with illegal=1.
  - illegal=0 in every other case.
- Overflow and zero are the ALU's concern. This stage does no arithmetic beyond extension.

Decomposition:
- Package alu_defs_pkg:
  - ALUctl constants ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR.
  - ALUOp codes.
  - FUNCT_* codes.
  - The alu_ctl_decode function, which returns {illegal, ALUctl}.
- Sub-module reg_file_32x32: 2R1W with r0 hardwired to 0. The bypass logic stays in the parent.

Test Plan:
- Reset, then wb writes r1=FFFF_FFFD and r2=0000_0007; issue alu_op=10, funct=100000, rs=1, rt=2 -> one cycle later out_valid=1, A=FFFF_FFFD, B=0000_0007, ALUctl=0010, illegal=0.
- Same operands with funct=100010 / 100111 / 100100 / 101010 -> ALUctl=0110 / 1100 / 0000 / 0111; funct=111111 -> ALUctl=0010, illegal=1.
- alu_src=1, imm16=8000, imm_zext=0 -> B=FFFF_8000; imm_zext=1 -> B=0000_8000; alu_op=11 -> ALUctl=0001.
- Load rs=3 in the same cycle as wb_en=1, wb_addr=3, wb_data=7000_0000 -> A=7000_0000. A write to r0 with any value followed by a read of rs=0 -> A=0.
- Hold out_ready=0 for 3 cycles with in_valid=1 and a write to r1=A000_0000 -> in_ready=0 and A/B/ALUctl unchanged. On out_ready=1 the new instruction loads the next cycle with A=A000_0000.
- flush with in_valid=1 -> out_valid=0 next cycle. rst asserted while out_valid=1 -> all outputs 0 next edge, and registers read 0.
